// File: rtl/bist_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bist_seq_ctrl -- built-in self-test sequencer for one small sequential CUT.
//
// A run has these phases:
//   1. Flush the CUT state with INIT_VEC for INIT_CYC cycles.
//   2. Apply n_pat pseudo-random patterns from an LFSR.
//   3. Compact each CUT response into a MISR.
//   4. Compare the final signature against exp_sig.
//
// The CUT has no reset of its own. Every run therefore begins with the flush.
//
// Ports
//   CK          clock, rising edge
//   RN          asynchronous active-low reset
//   start       run request (level); only looked at in IDLE
//   abort       terminate the current run; ignored in IDLE
//   n_pat       pattern count, latched when leaving IDLE
//   exp_sig     expected signature, sampled in CMP
//   cut_out     CUT combinational outputs (captured in the same RUN cycle)
//   cut_in      CUT stimulus: LFSR in RUN, INIT_VEC otherwise
//   cut_en      high while a counted pattern is applied
//   busy        high in INIT, RUN and CMP
//   done        high in DONE
//   pass        signature matched exp_sig (meaningful while done)
//   signature   MISR contents
//   pat_cnt     patterns applied in the current or last run
// ---------------------------------------------------------------------------
module bist_seq_ctrl #(
    parameter int              N_IN      = 7,
    parameter int              N_OUT     = 7,
    parameter logic [N_IN-1:0] LFSR_TAPS = 7'h60,
    parameter logic [N_OUT-1:0] MISR_TAPS = 7'h60,
    parameter logic [N_IN-1:0] SEED      = 7'h01,
    parameter logic [N_IN-1:0] INIT_VEC  = 7'h00,
    parameter int              INIT_CYC  = 4
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      n_pat,
    input  logic [N_OUT-1:0] exp_sig,
    input  logic [N_OUT-1:0] cut_out,
    output logic [N_IN-1:0]  cut_in,
    output logic             cut_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_OUT-1:0] signature,
    output logic [15:0]      pat_cnt
);

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [N_IN-1:0] SEED_EFF =
        (SEED == '0) ? {{(N_IN-1){1'b0}}, 1'b1} : SEED;

    localparam int ICW = (INIT_CYC > 1) ? $clog2(INIT_CYC + 1) : 1;
    localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_CMP,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [N_IN-1:0]  lfsr_q, lfsr_d;
    logic [N_OUT-1:0] misr_q, misr_d;
    logic [15:0]      pat_cnt_q, pat_cnt_d;
    logic [15:0]      npat_q, npat_d;
    logic [ICW-1:0]   init_cnt_q, init_cnt_d;
    logic             pass_q, pass_d;

    // The outputs are registered. They are decoded from the next state, so
    // they line up with state_q in every cycle.
    logic [N_IN-1:0]  cut_in_q;
    logic             cut_en_q, busy_q, done_q;

    logic [N_IN-1:0]  lfsr_step;
    logic [N_OUT-1:0] misr_step;

    // Fibonacci-style shift-left LFSR.
    // The MISR shifts the same way and then folds in the CUT response.
    assign lfsr_step = {lfsr_q[N_IN-2:0], ^(lfsr_q & LFSR_TAPS)};
    assign misr_step = {misr_q[N_OUT-2:0], ^(misr_q & MISR_TAPS)} ^ cut_out;

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        misr_d     = misr_q;
        pat_cnt_d  = pat_cnt_q;
        npat_d     = npat_q;
        init_cnt_d = init_cnt_q;
        pass_d     = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_INIT;
                    lfsr_d     = SEED_EFF;
                    misr_d     = '0;
                    pat_cnt_d  = '0;
                    pass_d     = 1'b0;
                    npat_d     = n_pat;
                    init_cnt_d = '0;
                end
            end
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = (npat_q == 16'd0) ? S_CMP : S_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                lfsr_d    = lfsr_step;
                misr_d    = misr_step;
                pat_cnt_d = pat_cnt_q + 16'd1;
                // pat_cnt_q < npat_q holds in RUN, so this increment never wraps.
                if (pat_cnt_d == npat_q) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                pass_d  = (misr_q == exp_sig);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything. The partial signature and count stay
        // visible, and the pattern in flight is not compacted.
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            lfsr_d    = lfsr_q;
            misr_d    = misr_q;
            pat_cnt_d = pat_cnt_q;
            pass_d    = pass_q;
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED_EFF;
            misr_q     <= '0;
            pat_cnt_q  <= '0;
            npat_q     <= '0;
            init_cnt_q <= '0;
            pass_q     <= 1'b0;
            cut_in_q   <= INIT_VEC;
            cut_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            misr_q     <= misr_d;
            pat_cnt_q  <= pat_cnt_d;
            npat_q     <= npat_d;
            init_cnt_q <= init_cnt_d;
            pass_q     <= pass_d;
            // In RUN, cut_in always equals lfsr_q. The CUT response for that
            // pattern is then compacted on the edge that ends the cycle.
            cut_in_q   <= (state_d == S_RUN) ? lfsr_d : INIT_VEC;
            cut_en_q   <= (state_d == S_RUN);
            busy_q     <= (state_d == S_INIT) || (state_d == S_RUN) ||
                          (state_d == S_CMP);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign cut_in    = cut_in_q;
    assign cut_en    = cut_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q;
    assign pat_cnt   = pat_cnt_q;

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Testbench for bist_seq_ctrl.
// A behavioural CUT drives cut_out from cut_in. Expected patterns, signatures
// and timing come from a plain-arithmetic model of the LFSR/MISR rules.
module tb_bist_seq_ctrl;

    logic        CK = 1'b0;
    logic        RN = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] n_pat = 16'd0;
    logic [6:0]  exp_sig = 7'h00;
    logic [6:0]  cut_out;
    logic [6:0]  cut_in;
    logic        cut_en, busy, done, pass;
    logic [6:0]  signature;
    logic [15:0] pat_cnt;

    int n_chk = 0;
    int n_err = 0;

    // CUT model: either tied to a constant or a fixed scrambling of cut_in.
    bit         cut_tie   = 1'b1;
    logic [6:0] cut_const = 7'h00;
    logic [6:0] cut_key   = 7'h00;

    logic [6:0] seen [128];

    bist_seq_ctrl dut (
        .CK(CK), .RN(RN), .start(start), .abort(abort), .n_pat(n_pat),
        .exp_sig(exp_sig), .cut_out(cut_out), .cut_in(cut_in),
        .cut_en(cut_en), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .pat_cnt(pat_cnt)
    );

    always #5 CK = ~CK;

    function automatic logic [6:0] cut_fn(input logic [6:0] x);
        if (cut_tie) return cut_const;
        return {x[5:0], x[6]} ^ cut_key ^ {3'b000, x[6:3]};
    endfunction

    always_comb cut_out = cut_fn(cut_in);

    // x^7+x^6+1 sequence generator.
    function automatic logic [6:0] lfsr_nx(input logic [6:0] x);
        return {x[5:0], x[6] ^ x[5]};
    endfunction

    // Signature after n patterns from seed 1, MISR starting at 0.
    function automatic logic [6:0] model_sig(input int n);
        logic [6:0] p, m;
        p = 7'h01;
        m = 7'h00;
        for (int k = 0; k < n; k++) begin
            m = {m[5:0], m[6] ^ m[5]} ^ cut_fn(p);
            p = lfsr_nx(p);
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete run from IDLE through DONE and back to IDLE.
    // hold: extra DONE cycles with start still high.
    // wiggle: drop start during INIT; the sequencer must ignore it.
    task automatic do_run(input int n, input logic [6:0] es, input int hold, input bit wiggle);
        logic [6:0] sig_m, p;
        int cyc, ncen, bad_pat, bad_init, bad_busy;
        bit got_done;
        sig_m = model_sig(n);
        p = 7'h01;
        cyc = 0; ncen = 0; bad_pat = 0; bad_init = 0; bad_busy = 0;
        got_done = 1'b0;
        @(negedge CK);
        start = 1'b1; n_pat = 16'(n); exp_sig = es;
        while (!got_done && cyc < n + 50) begin
            @(negedge CK);
            cyc++;
            if (wiggle && cyc == 2) start = 1'b0;
            if (wiggle && cyc == 3) start = 1'b1;
            if (cut_en) begin
                if (cut_in !== p) bad_pat++;
                if (ncen < 128) seen[ncen] = cut_in;
                ncen++;
                p = lfsr_nx(p);
            end else if (cut_in !== 7'h00) begin
                bad_init++;
            end
            if (done) got_done = 1'b1;
            else if (!busy) bad_busy++;
        end
        chk("done_seen", 32'(got_done), 1);
        chk("latency", cyc - 1, 4 + n + 1);
        chk("cut_en_cycles", ncen, n);
        chk("pattern_seq", bad_pat, 0);
        chk("flush_vec", bad_init, 0);
        chk("busy_in_run", bad_busy, 0);
        chk("busy_at_done", 32'(busy), 0);
        chk("signature", 32'(signature), 32'(sig_m));
        chk("pass", 32'(pass), 32'(sig_m == es));
        chk("pat_cnt", 32'(pat_cnt), n);
        repeat (hold) @(negedge CK);
        chk("done_held", 32'(done), 1);
        start = 1'b0;
        @(negedge CK);
        chk("done_clear", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("sig_after", 32'(signature), 32'(sig_m));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, cnt;
        bit distinct_ok;
        logic [127:0] mark;
        logic [6:0] exp7 [7];
        logic [6:0] es;
        int n;

        // Reset values, sampled while RN is held low.
        #12;
        chk("rst_cut_in", 32'(cut_in), 32'h00);
        chk("rst_cut_en", 32'(cut_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_sig", 32'(signature), 0);
        chk("rst_pat_cnt", 32'(pat_cnt), 0);
        @(negedge CK);
        RN = 1'b1;

        // Directed: n=3 with the CUT tied to zero.
        cut_tie = 1'b1; cut_const = 7'h00;
        do_run(3, 7'h00, 2, 1'b0);
        chk("t1_pat0", 32'(seen[0]), 32'h01);
        chk("t1_pat2", 32'(seen[2]), 32'h04);

        // The CUT is tied to 01 and n=2, so the signature must be 03.
        cut_const = 7'h01;
        do_run(2, 7'h03, 0, 1'b0);
        chk("t2_sig_const", 32'(signature), 32'h03);
        chk("t2_pass", 32'(pass), 1);
        do_run(2, 7'h02, 0, 1'b0);
        chk("t2_fail_pass", 32'(pass), 0);

        // A full LFSR period.
        cut_const = 7'h00;
        do_run(127, 7'h00, 0, 1'b0);
        exp7[0] = 7'h01; exp7[1] = 7'h02; exp7[2] = 7'h04; exp7[3] = 7'h08;
        exp7[4] = 7'h10; exp7[5] = 7'h20; exp7[6] = 7'h41;
        for (int i = 0; i < 7; i++) chk("t3_head", 32'(seen[i]), 32'(exp7[i]));
        mark = '0;
        distinct_ok = 1'b1;
        for (int i = 0; i < 127; i++) begin
            if (seen[i] == 7'h00 || mark[seen[i]]) distinct_ok = 1'b0;
            mark[seen[i]] = 1'b1;
        end
        chk("t3_distinct", 32'(distinct_ok), 1);

        // n=0: go straight from the flush to compare.
        do_run(0, 7'h00, 1, 1'b0);

        // Abort in the second RUN cycle.
        cut_tie = 1'b0; cut_key = 7'h35;
        @(negedge CK);
        start = 1'b1; n_pat = 16'd10; exp_sig = 7'h00;
        g = 0; cnt = 0;
        while (cnt < 2 && g < 40) begin
            @(negedge CK);
            g++;
            if (cut_en) cnt++;
            if (done) chk("abort_early_done", 32'(done), 0);
        end
        chk("abort_reach_run", cnt, 2);
        abort = 1'b1;
        @(negedge CK);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_cut_en", 32'(cut_en), 0);
        chk("abort_pat_cnt", 32'(pat_cnt), 1);
        chk("abort_pass", 32'(pass), 0);
        // start is still high, so the sequencer re-arms and runs again.
        g = 0;
        while (!done && g < 60) begin
            @(negedge CK);
            g++;
        end
        chk("rerun_done", 32'(done), 1);
        chk("rerun_sig", 32'(signature), 32'(model_sig(10)));
        chk("rerun_pat_cnt", 32'(pat_cnt), 10);
        start = 1'b0;
        @(negedge CK);

        // Assert RN in the middle of RUN.
        start = 1'b1; n_pat = 16'd20;
        g = 0; cnt = 0;
        while (cnt < 3 && g < 40) begin
            @(negedge CK);
            g++;
            if (cut_en) cnt++;
        end
        RN = 1'b0;
        start = 1'b0;
        #1;
        chk("rn_busy", 32'(busy), 0);
        chk("rn_cut_en", 32'(cut_en), 0);
        chk("rn_cut_in", 32'(cut_in), 0);
        chk("rn_sig", 32'(signature), 0);
        chk("rn_pat_cnt", 32'(pat_cnt), 0);
        @(negedge CK);
        RN = 1'b1;
        @(negedge CK);
        chk("rn_stays_idle", 32'(busy), 0);

        // Random runs against the model.
        for (int i = 0; i < 8; i++) begin
            cut_tie = ($urandom_range(0, 3) == 0);
            cut_const = 7'($urandom);
            cut_key = 7'($urandom);
            n = $urandom_range(1, 40);
            es = (i % 2 == 0) ? model_sig(n) : 7'($urandom);
            do_run(n, es, $urandom_range(0, 3), (i % 3) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
